// File: rtl/packet_framer36_pkg.sv
// ============================================================================
// packet_framer36_pkg : shared constants, state encoding and length helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package packet_framer36_pkg;

    localparam int          HDR_WORDS      = 11;
    localparam int          SOF_BIT        = 32;
    localparam int          EOF_BIT        = 33;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] IPV4_VER_IHL   = 16'h4500;
    localparam logic [7:0]  IPV4_TTL       = 8'h40;
    localparam logic [7:0]  IPV4_PROTO_UDP = 8'h11;
    localparam logic [15:0] MAX_SIZE       = 16'd16376;
    localparam logic [15:0] UDP_OVERHEAD   = 16'd8;
    localparam logic [15:0] IP_OVERHEAD    = 16'd28;

    localparam int OFF_DST_MAC_HI = 0;
    localparam int OFF_DST_MAC_LO = 1;
    localparam int OFF_SRC_MAC_HI = 2;
    localparam int OFF_SRC_MAC_LO = 3;
    localparam int OFF_SRC_IP     = 4;
    localparam int OFF_DST_IP     = 5;
    localparam int OFF_PORTS      = 6;
    localparam int SETTING_COUNT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_HDR   = 3'd2,
        ST_FIRST = 3'd3,
        ST_LIVE  = 3'd4,
        ST_DROP  = 3'd5
    } state_t;

    // Byte length of a header plus a payload of 'size' 32-bit words.
    function automatic logic [15:0] frame_len(input logic [15:0] size,
                                              input logic [15:0] overhead);
        return overhead + (size << 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ip_hdr_checksum.sv
// ============================================================================
// ip_hdr_checksum : two-stage IPv4 header checksum (sum, then fold + invert)
// Revision : 1.0
// ============================================================================
`default_nettype none

module ip_hdr_checksum
    import packet_framer36_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ip_len,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    output logic [15:0] csum
);

    logic [19:0] sum_d;
    logic [19:0] sum_q;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Identification and flags/fragment words are zero and drop out of the sum.
    always_comb begin
        sum_d = 20'(IPV4_VER_IHL) + 20'(ip_len) + 20'({IPV4_TTL, IPV4_PROTO_UDP})
              + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
              + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
        fold1 = {1'b0, sum_q[15:0]} + {13'd0, sum_q[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            csum  <= '0;
        end else begin
            sum_q <= sum_d;
            csum  <= ~fold2;
        end
    end

endmodule

`default_nettype wire

// File: rtl/setting_reg.sv
// ============================================================================
// setting_reg : one addressable register on the settings bus
// Revision : 1.0
// ============================================================================
`default_nettype none

module setting_reg #(
    parameter int ADDR  = 0,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      in,
    output logic [WIDTH-1:0] out
);

    localparam logic [7:0] MY_ADDR = ADDR[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (strobe && (addr == MY_ADDR)) begin
            out <= in[WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/packet_framer36.sv
// ============================================================================
// packet_framer36 : wraps VRT packets in Ethernet/IPv4/UDP (2-byte padded)
// Revision : 1.0
// ============================================================================
`default_nettype none

module packet_framer36
    import packet_framer36_pkg::*;
#(
    parameter int BASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [35:0] inp_data,
    input  logic        inp_valid,
    output logic        inp_ready,
    output logic [35:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] drop_count
);

    logic [31:0] set_q [SETTING_COUNT];

    for (genvar i = 0; i < SETTING_COUNT; i++) begin : g_settings
        setting_reg #(.ADDR(BASE + i), .WIDTH(32)) u_reg (
            .clk    (clk),
            .rst    (rst),
            .strobe (set_stb),
            .addr   (set_addr),
            .in     (set_data),
            .out    (set_q[i])
        );
    end

    logic unused_set_bits;
    assign unused_set_bits = ^{set_q[OFF_DST_MAC_HI][31:16], set_q[OFF_SRC_MAC_HI][31:16]};

    state_t      state, next_state;
    logic [3:0]  hdr_idx, hdr_idx_d;
    logic        calc_cnt, calc_cnt_d;
    logic        drop_inc;
    logic [35:0] vrt_hdr;
    logic [47:0] lat_dst_mac, lat_src_mac;
    logic [31:0] lat_src_ip, lat_dst_ip, lat_ports;
    logic [15:0] ip_len, udp_len, csum;
    logic [35:0] hdr_word;
    logic        sof_accept;
    logic        size_bad;

    assign sof_accept = (state == ST_IDLE) && inp_valid && inp_data[SOF_BIT];
    assign size_bad   = (inp_data[15:0] == 16'd0) || (inp_data[15:0] > MAX_SIZE);
    assign ip_len     = frame_len(vrt_hdr[15:0], IP_OVERHEAD);
    assign udp_len    = frame_len(vrt_hdr[15:0], UDP_OVERHEAD);

    // Settings are snapshotted with the VRT header so mid-packet writes wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            vrt_hdr     <= '0;
            lat_dst_mac <= '0;
            lat_src_mac <= '0;
            lat_src_ip  <= '0;
            lat_dst_ip  <= '0;
            lat_ports   <= '0;
        end else if (sof_accept) begin
            vrt_hdr     <= inp_data;
            lat_dst_mac <= {set_q[OFF_DST_MAC_HI][15:0], set_q[OFF_DST_MAC_LO]};
            lat_src_mac <= {set_q[OFF_SRC_MAC_HI][15:0], set_q[OFF_SRC_MAC_LO]};
            lat_src_ip  <= set_q[OFF_SRC_IP];
            lat_dst_ip  <= set_q[OFF_DST_IP];
            lat_ports   <= set_q[OFF_PORTS];
        end
    end

    ip_hdr_checksum u_csum (
        .clk    (clk),
        .rst    (rst),
        .ip_len (ip_len),
        .src_ip (lat_src_ip),
        .dst_ip (lat_dst_ip),
        .csum   (csum)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= ST_IDLE;
            hdr_idx    <= '0;
            calc_cnt   <= 1'b0;
            drop_count <= '0;
        end else begin
            state    <= next_state;
            hdr_idx  <= hdr_idx_d;
            calc_cnt <= calc_cnt_d;
            if (drop_inc && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_comb begin
        hdr_word = '0;
        case (hdr_idx)
            4'd0:    hdr_word = {4'b0001, 16'h0000, lat_dst_mac[47:32]};
            4'd1:    hdr_word = {4'b0000, lat_dst_mac[31:0]};
            4'd2:    hdr_word = {4'b0000, lat_src_mac[47:16]};
            4'd3:    hdr_word = {4'b0000, lat_src_mac[15:0], ETHERTYPE_IPV4};
            4'd4:    hdr_word = {4'b0000, IPV4_VER_IHL, ip_len};
            4'd5:    hdr_word = '0;
            4'd6:    hdr_word = {4'b0000, IPV4_TTL, IPV4_PROTO_UDP, csum};
            4'd7:    hdr_word = {4'b0000, lat_src_ip};
            4'd8:    hdr_word = {4'b0000, lat_dst_ip};
            4'd9:    hdr_word = {4'b0000, lat_ports};
            4'd10:   hdr_word = {4'b0000, udp_len, 16'h0000};
            default: hdr_word = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        hdr_idx_d  = hdr_idx;
        calc_cnt_d = calc_cnt;
        drop_inc   = 1'b0;
        inp_ready  = 1'b0;
        out_valid  = 1'b0;
        out_data   = hdr_word;
        case (state)
            ST_IDLE: begin
                inp_ready  = 1'b1;
                calc_cnt_d = 1'b0;
                if (sof_accept) begin
                    if (size_bad) begin
                        drop_inc   = 1'b1;
                        next_state = inp_data[EOF_BIT] ? ST_IDLE : ST_DROP;
                    end else begin
                        next_state = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                calc_cnt_d = calc_cnt + 1'b1;
                if (calc_cnt) begin
                    next_state = ST_HDR;
                    hdr_idx_d  = '0;
                end
            end
            ST_HDR: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (hdr_idx == 4'(HDR_WORDS - 1)) begin
                        next_state = ST_FIRST;
                        hdr_idx_d  = '0;
                    end else begin
                        hdr_idx_d = hdr_idx + 4'd1;
                    end
                end
            end
            ST_FIRST: begin
                out_valid         = 1'b1;
                out_data          = vrt_hdr;
                out_data[SOF_BIT] = 1'b0;
                if (out_ready) begin
                    next_state = vrt_hdr[EOF_BIT] ? ST_IDLE : ST_LIVE;
                end
            end
            ST_LIVE: begin
                out_data          = inp_data;
                out_data[SOF_BIT] = 1'b0;
                out_valid         = inp_valid;
                inp_ready         = out_ready;
                if (inp_valid && out_ready && inp_data[EOF_BIT]) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DROP: begin
                inp_ready = 1'b1;
                if (inp_valid && inp_data[EOF_BIT]) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_packet_framer36.sv
// ============================================================================
// tb_packet_framer36 : vector table plus hand sequences, scoreboard on output
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_packet_framer36;

    logic        clk = 1'b0;
    logic        rst, clr, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [35:0] inp_data;
    logic        inp_valid, inp_ready;
    logic [35:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    packet_framer36 #(.BASE(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .inp_data   (inp_data),
        .inp_valid  (inp_valid),
        .inp_ready  (inp_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          out_cnt  = 0;
    int          exp_drop = 0;
    int          ready_mode = 0;
    logic [35:0] exp_q[$];
    logic [35:0] out_log[$];
    logic [35:0] stall_data;
    logic        stall_pend = 1'b0;

    logic [47:0] m_dst_mac = '0, m_src_mac = '0;
    logic [31:0] m_src_ip = '0, m_dst_ip = '0, m_ports = '0;

    typedef struct {
        int size;
        int nwords;
        int lead;
        int rmode;
        int exp_out;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // 0: ready held high, 1: toggles every cycle, 2: driven by hand
    always @(negedge clk) begin
        if (ready_mode == 0)      out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = ~out_ready;
    end

    always begin
        @(negedge clk);
        #2;
        if (stall_pend && out_valid) check("stall_hold", 64'(out_data), 64'(stall_data));
        stall_pend = 1'b0;
        if (out_valid && !out_ready) begin
            stall_pend = 1'b1;
            stall_data = out_data;
        end
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            out_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got %h, required no output", out_data);
            end else begin
                check("out_word", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [15:0] model_csum(input logic [15:0] ip_len);
        logic [31:0] s;
        s = 32'h4500 + 32'(ip_len) + 32'h4011
          + 32'(m_src_ip[31:16]) + 32'(m_src_ip[15:0])
          + 32'(m_dst_ip[31:16]) + 32'(m_dst_ip[15:0]);
        while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
        return ~s[15:0];
    endfunction

    task automatic push_frame(input int size, input logic [35:0] words[$]);
        logic [15:0] ip_len, udp_len;
        logic [35:0] w;
        ip_len  = 16'(28 + 4 * size);
        udp_len = 16'(8 + 4 * size);
        exp_q.push_back({4'b0001, 16'h0000, m_dst_mac[47:32]});
        exp_q.push_back({4'b0000, m_dst_mac[31:0]});
        exp_q.push_back({4'b0000, m_src_mac[47:16]});
        exp_q.push_back({4'b0000, m_src_mac[15:0], 16'h0800});
        exp_q.push_back({4'b0000, 16'h4500, ip_len});
        exp_q.push_back(36'h0);
        exp_q.push_back({4'b0000, 8'h40, 8'h11, model_csum(ip_len)});
        exp_q.push_back({4'b0000, m_src_ip});
        exp_q.push_back({4'b0000, m_dst_ip});
        exp_q.push_back({4'b0000, m_ports});
        exp_q.push_back({4'b0000, udp_len, 16'h0000});
        foreach (words[i]) begin
            w = words[i];
            w[32] = 1'b0;
            exp_q.push_back(w);
        end
    endtask

    task automatic write_set(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(negedge clk);
        set_stb = 1'b0;
        case (a)
            8'd0: m_dst_mac[47:32] = d[15:0];
            8'd1: m_dst_mac[31:0]  = d;
            8'd2: m_src_mac[47:32] = d[15:0];
            8'd3: m_src_mac[31:0]  = d;
            8'd4: m_src_ip         = d;
            8'd5: m_dst_ip         = d;
            8'd6: m_ports          = d;
            default: ;
        endcase
    endtask

    task automatic send_word(input logic [35:0] d);
        int budget = 2000;
        bit hs = 1'b0;
        @(negedge clk);
        inp_data = d; inp_valid = 1'b1;
        while (!hs && budget > 0) begin
            #1;
            hs = inp_ready;
            @(posedge clk);
            if (!hs) begin
                @(negedge clk);
                budget--;
            end
        end
        if (!hs) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: inp_ready stayed 0, required 1 within budget");
        end
    endtask

    task automatic end_input();
        @(negedge clk);
        inp_valid = 1'b0;
    endtask

    function automatic void build_pkt(input int size, input int nwords, output logic [35:0] w[$]);
        logic [35:0] x;
        w.delete();
        w.push_back({2'b00, (nwords == 1), 1'b1, 16'hABCD, 16'(size)});
        for (int i = 1; i < nwords; i++) begin
            x = {2'b00, (i == nwords - 1), (i == 2), $urandom()};
            w.push_back(x);
        end
    endfunction

    task automatic send_packet(input int size, input int nwords, input int lead);
        logic [35:0] w[$];
        build_pkt(size, nwords, w);
        if (size != 0 && size <= 16376) push_frame(size, w);
        else exp_drop++;
        for (int i = 0; i < lead; i++) send_word({4'b0000, $urandom()});
        foreach (w[i]) send_word(w[i]);
        end_input();
    endtask

    task automatic drain();
        int budget = 3000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [35:0] w[$];
        int          budget;

        rst = 1'b1; clr = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        inp_data = '0; inp_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_inp_ready", 64'(inp_ready), 64'(1));
        check("rst_drop_count", 64'(drop_count), 64'(0));

        // Settings come up zero after reset.
        out_cnt = 0;
        send_packet(2, 2, 0);
        drain();
        check("zero_settings_count", 64'(out_cnt), 64'(13));

        write_set(8'd0, 32'h0000_0050);
        write_set(8'd1, 32'hC285_3FFF);
        write_set(8'd2, 32'h0000_0011);
        write_set(8'd3, 32'h2233_4455);
        write_set(8'd4, 32'hC0A8_0A02);
        write_set(8'd5, 32'hC0A8_0A01);
        write_set(8'd6, {16'd49152, 16'd49153});

        // Reference packet with first-output latency checks.
        ready_mode = 0;
        out_cnt = 0;
        out_log.delete();
        build_pkt(4, 4, w);
        push_frame(4, w);
        send_word(w[0]);
        @(negedge clk); #1;
        check("lat_n1_valid", 64'(out_valid), 64'(0));
        check("lat_n1_ready", 64'(inp_ready), 64'(0));
        @(negedge clk); #1;
        check("lat_n2_valid", 64'(out_valid), 64'(0));
        @(negedge clk); #1;
        check("lat_n3_valid", 64'(out_valid), 64'(1));
        for (int i = 1; i < 4; i++) send_word(w[i]);
        end_input();
        drain();
        check("ref_count", 64'(out_log.size()), 64'(15));
        check("ref_w0_flags", 64'(out_log[0][35:32]), 64'(4'b0001));
        check("ref_ip_len", 64'(out_log[4][15:0]), 64'(16'h002C));
        check("ref_csum", 64'(out_log[6][15:0]), 64'(16'hE56D));
        check("ref_udp_len", 64'(out_log[10][31:16]), 64'(16'h0018));
        check("ref_w14_eof", 64'(out_log[14][33]), 64'(1));

        vecs.push_back('{4,     4, 0, 0, 15});
        vecs.push_back('{4,     4, 0, 1, 15});
        vecs.push_back('{0,     3, 0, 0, 0});
        vecs.push_back('{4,     4, 2, 0, 15});
        vecs.push_back('{1,     1, 0, 0, 12});
        vecs.push_back('{16377, 2, 0, 1, 0});
        vecs.push_back('{16376, 3, 0, 1, 14});
        vecs.push_back('{0,     1, 0, 0, 0});
        vecs.push_back('{5,     5, 1, 1, 16});
        foreach (vecs[v]) begin
            ready_mode = vecs[v].rmode;
            out_cnt = 0;
            out_log.delete();
            send_packet(vecs[v].size, vecs[v].nwords, vecs[v].lead);
            drain();
            check($sformatf("vec%0d_count", v), 64'(out_cnt), 64'(vecs[v].exp_out));
            check($sformatf("vec%0d_drops", v), 64'(drop_count), 64'(16'(exp_drop)));
            if (vecs[v].size == 1) begin
                check("single_ip_len", 64'(out_log[4][15:0]), 64'(16'h0020));
                check("single_w11_eof", 64'(out_log[11][33]), 64'(1));
            end
        end

        // A settings write mid-packet only takes effect on the following packet.
        ready_mode = 0;
        out_cnt = 0;
        fork
            send_packet(3, 3, 0);
            begin
                repeat (4) @(negedge clk);
                write_set(8'd4, 32'h0A00_0001);
            end
        join
        drain();
        out_log.delete();
        send_packet(2, 2, 0);
        drain();
        check("new_src_ip", 64'(out_log[7][31:0]), 64'(32'h0A00_0001));

        // Flush while header word 5 is presented.
        ready_mode = 2;
        out_ready = 1'b0;
        out_cnt = 0;
        build_pkt(4, 4, w);
        push_frame(4, w);
        send_word(w[0]);
        end_input();
        budget = 20;
        #1;
        while (!out_valid && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        check("clr_hdr_reached", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        clr = 1'b1;
        #1;
        check("clr_w5_data", 64'(out_data), 64'(36'h0));
        check("clr_pre_count", 64'(out_cnt), 64'(5));
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("clr_out_valid", 64'(out_valid), 64'(0));
        check("clr_inp_ready", 64'(inp_ready), 64'(1));
        check("clr_drop_count", 64'(drop_count), 64'(0));
        exp_q.delete();
        exp_drop = 0;
        ready_mode = 0;
        out_cnt = 0;
        out_log.delete();
        send_packet(4, 4, 0);
        drain();
        check("post_clr_count", 64'(out_cnt), 64'(15));
        check("post_clr_dst_mac", 64'(out_log[1][31:0]), 64'(32'hC285_3FFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
